multiply_unit: RTL and testbench
================================

# multiply_unit

Iterative multiply/multiply-accumulate unit in the execute stage, directly downstream of the main decoder. It is launched whenever the decoder flags a multiply instruction (`mult`) and its condition passes, and computes MUL/MLA (32-bit result) and UMULL/SMULL/UMLAL/SMLAL (64-bit result) with a shift-add datapath. While it works, it stalls the pipeline. It returns the low/high result words and N/Z flags to the writeback and flag logic.

## Interface
- `WIDTH`, 32, operand width; the result is `2*WIDTH` wide.
- `BITS_PER_CYCLE`, 1, multiplier bits retired per iteration; must divide `WIDTH`; `N = WIDTH/BITS_PER_CYCLE` iterations.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request; equals decoder `mult` AND condition-pass.
- `long_mul`  in  1  1 = 64-bit result (decoder `reg_w3` with `mult`).
- `signed_mul`  in  1  1 = signed operands; only meaningful when `long_mul`=1.
- `accumulate`  in  1  add `{acc_hi,acc_lo}` (long) or `acc_lo` (short) to the product.
- `src_a`, `src_b`  in  WIDTH  multiplicand, multiplier.
- `acc_lo`, `acc_hi`  in  WIDTH  accumulate operands.
- `busy`  out  1  1 in CALC and FIX states.
- `stall`  out  1  combinational: `busy | (start & state==IDLE)`.
- `done`  out  1  one-cycle pulse; results are valid.
- `result_lo`, `result_hi`  out  WIDTH  registered product words.
- `n_flag`, `z_flag`  out  1  registered flags of the result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 latches `src_a`, `src_b`, `acc_*`, `long_mul`, `signed_mul` and `accumulate`.
  - It clears the partial product and the iteration counter, then moves to CALC.
  - If `signed_mul & long_mul`, it latches the magnitudes of `src_a`/`src_b` and records `neg = a[msb]^b[msb]`.
- CALC: each cycle retires `BITS_PER_CYCLE` multiplier bits (shift-add into a 2*WIDTH accumulator). After iteration N, it moves to FIX.
- FIX, single cycle, in this order:
  - Two's-complement negate the 2*WIDTH product if `neg`.
  - Add the accumulate operand, modulo 2^(2*WIDTH) for long or 2^WIDTH for short.
  - Write the result registers and flags, then move to DONE.
- Result rules:
  - Short: `result_lo` = low WIDTH bits and `result_hi` = 0.
  - Short: `n_flag = result_lo[msb]` and `z_flag = (result_lo==0)`.
  - Long: `n_flag = result_hi[msb]` and `z_flag = ({hi,lo}==0)`.
- DONE: `done`=1 for exactly this cycle.
  - If `start`=1, it accepts a new op exactly as IDLE does and goes to CALC (back-to-back issue).
  - Otherwise it goes to IDLE.
- `start` in CALC/FIX is ignored; upstream is stalled, so this is an illegal but harmless case.
- Results and flags hold their values until the next FIX cycle.
- Reset: state becomes IDLE and all outputs become 0: `busy`, `done`, `result_*`, `n_flag`, `z_flag`. An in-flight operation is aborted with no `done` pulse. `stall` follows its equation.

## Timing
- `start` sampled at edge 0 → CALC after edge 0.
- Iterations run at edges 1..N; FIX occupies the cycle after edge N.
- Results and `done` become visible after edge N+1.
- IDLE (or a new CALC) after edge N+2.
- Default N=32: `done` is high 33 edges after the start edge. `busy` is high for N+1 cycles.
- `stall` is high from the start cycle through FIX. It is low in the DONE cycle so the pipeline advances and consumes the results.
- `BITS_PER_CYCLE`=4 gives N=8; `done` comes 9 edges after start.

## Test plan
- MUL 7×6, short, unsigned, no accumulate → `result_lo`=42, `result_hi`=0, N=0, Z=0. `done` comes exactly 33 edges after start; `busy` is high for 33 cycles.
- UMULL 0xFFFFFFFF×0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, N=1, Z=0.
- SMULL −1×2 → `{hi,lo}`=0xFFFFFFFF_FFFFFFFE, N=1. Also 0×0x12345678 → Z=1.
- MLA 0x80000000×2 + `acc_lo`=5 → `result_lo`=5 (wraps), `result_hi`=0, Z=0.
- UMLAL 0xFFFFFFFF×1 with acc {1,0xFFFFFFFF} → hi=2, lo=0xFFFFFFFE.
- Pulse `start` again mid-CALC → ignored, one `done` only.
- `start` held in the DONE cycle → second op begins, and its `done` arrives 33 edges later.
- Assert `reset` at iteration 10 → next cycle state IDLE, all outputs 0, no `done`.

Source files
------------

// File: rtl/multiply_unit.sv
// rtl/multiply_unit.sv - iterative shift-add MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit
// Stalls the pipeline while CALC/FIX run; results and N/Z flags are registered in FIX.
module multiply_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long_mul,
  input  logic             signed_mul,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             n_flag,
  output logic             z_flag
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [CW-1:0]    ONE_C = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    mcand, prod, addend, fixed, acc_ext, total;
  logic [WIDTH-1:0] mplier, acc_lo_r, acc_hi_r, a_mag, b_mag;
  logic [CW-1:0]    count;
  logic             neg, long_r, accum_r, load, take_sign;

  // DONE accepts a new op exactly like IDLE so back-to-back issue costs no bubble.
  assign load      = start & ((state == IDLE) | (state == DONE));
  assign busy      = (state == CALC) | (state == FIX);
  assign done      = (state == DONE);
  assign stall     = busy | (start & (state == IDLE));
  assign take_sign = signed_mul & long_mul;

  always_comb begin
    a_mag = src_a;
    b_mag = src_b;
    if (take_sign & src_a[WIDTH-1]) a_mag = ~src_a + ONE_W;
    if (take_sign & src_b[WIDTH-1]) b_mag = ~src_b + ONE_W;
  end

  always_comb begin
    addend = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) addend = addend + (mcand << j);
    end
  end

  always_comb begin
    fixed   = neg ? (~prod + ONE_P) : prod;
    acc_ext = '0;
    if (accum_r) acc_ext = long_r ? {acc_hi_r, acc_lo_r} : {{WIDTH{1'b0}}, acc_lo_r};
    total = fixed + acc_ext;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (count == LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result_lo <= '0;
      result_hi <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      count     <= '0;
      neg       <= 1'b0;
      long_r    <= 1'b0;
      accum_r   <= 1'b0;
      acc_lo_r  <= '0;
      acc_hi_r  <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        mcand    <= {{WIDTH{1'b0}}, a_mag};
        mplier   <= b_mag;
        prod     <= '0;
        count    <= '0;
        neg      <= take_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        long_r   <= long_mul;
        accum_r  <= accumulate;
        acc_lo_r <= acc_lo;
        acc_hi_r <= acc_hi;
      end else if (state == CALC) begin
        prod   <= prod + addend;
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        count  <= count + ONE_C;
      end
      if (state == FIX) begin
        if (long_r) begin
          result_lo <= total[WIDTH-1:0];
          result_hi <= total[PW-1:WIDTH];
          n_flag    <= total[PW-1];
          z_flag    <= (total == '0);
        end else begin
          result_lo <= total[WIDTH-1:0];
          result_hi <= '0;
          n_flag    <= total[WIDTH-1];
          z_flag    <= (total[WIDTH-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multiply_unit.sv
// tb/tb_multiply_unit.sv - directed bench for multiply_unit
// Each task drives one scenario and compares against hand-computed values.
module tb_multiply_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        long_mul = 1'b0;
  logic        signed_mul = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] src_a = '0, src_b = '0, acc_lo = '0, acc_hi = '0;
  logic        busy, stall, done, n_flag, z_flag;
  logic [31:0] result_lo, result_hi;

  int total = 0;
  int bad = 0;

  multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .long_mul(long_mul),
    .signed_mul(signed_mul), .accumulate(accumulate), .src_a(src_a),
    .src_b(src_b), .acc_lo(acc_lo), .acc_hi(acc_hi), .busy(busy),
    .stall(stall), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .n_flag(n_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  // Issues one op, optionally re-pulses start at iteration pulse_at, and
  // reports edges-to-done (0 = timed out) and the number of busy cycles.
  task automatic run_op(input logic l, input logic s, input logic ac,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input int pulse_at, output int lat, output int busy_cnt);
    repeat (2) @(posedge clk);
    @(negedge clk);
    long_mul = l; signed_mul = s; accumulate = ac;
    src_a = a; src_b = b; acc_lo = lo; acc_hi = hi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      if (busy) busy_cnt++;
      start = (i == pulse_at);
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, stall, n_flag, z_flag} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {busy, done, stall, n_flag, z_flag});
    end
    total++;
    if ({result_hi, result_lo} !== 64'h0) begin
      bad++;
      $display("FAIL reset_result got=%h want=0", {result_hi, result_lo});
    end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
    total++;
    if (bc !== 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=33", bc); end
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {32'd0, 32'd42, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mul_7x6 got=%h_%h n=%b z=%b want=0_2a n=0 z=0", result_hi, result_lo, n_flag, z_flag);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_long();
    int lat, bc;
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if ({lat, result_hi, result_lo, n_flag, z_flag} !== {32'd33, 32'hFFFFFFFE, 32'h1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL umull_max got=%0d %h_%h n=%b z=%b want=33 fffffffe_00000001 n=1 z=0", lat, result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL smull_neg got=%h_%h n=%b z=%b want=ffffffff_fffffffe n=1 z=0", result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b1, 1'b0, 32'd0, 32'h12345678, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {64'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL smull_zero got=%h_%h n=%b z=%b want=0_0 n=0 z=1", result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {32'h40000000, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL smull_minmin got=%h_%h n=%b z=%b want=40000000_0 n=0 z=0", result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd0, 32'd0, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag} !== {32'h0, 32'd21, 1'b0}) begin
      bad++;
      $display("FAIL smull_negneg got=%h_%h n=%b want=0_15 n=0", result_hi, result_lo, n_flag);
    end
  endtask

  task automatic test_accumulate();
    int lat, bc;
    run_op(1'b0, 1'b0, 1'b1, 32'h80000000, 32'd2, 32'd5, 32'hAAAA5555, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {32'h0, 32'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mla_wrap got=%h_%h n=%b z=%b want=0_5 n=0 z=0", result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, n_flag, z_flag} !== {32'd2, 32'hFFFFFFFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL umlal_carry got=%h_%h n=%b z=%b want=2_fffffffe n=0 z=0", result_hi, result_lo, n_flag, z_flag);
    end
    run_op(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd3, 32'd3, 32'd0, 0, lat, bc);
    total++;
    if ({result_hi, result_lo, z_flag} !== {64'h0, 1'b1}) begin
      bad++;
      $display("FAIL smlal_zero got=%h_%h z=%b want=0_0 z=1", result_hi, result_lo, z_flag);
    end
  endtask

  task automatic test_mid_start();
    int lat, bc, extra;
    run_op(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 5, lat, bc);
    total++;
    if ({lat, result_lo} !== {32'd33, 32'd81}) begin
      bad++;
      $display("FAIL midstart_op got=%0d %0d want=33 81", lat, result_lo);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL midstart_extra_done got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    long_mul = 1'b0; signed_mul = 1'b0; accumulate = 1'b0;
    src_a = 32'd7; src_b = 32'd6; start = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall_idle got=%b want=1", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
    src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    #1;
    total++;
    if ({stall, result_lo} !== {1'b0, 32'd42}) begin
      bad++;
      $display("FAIL b2b_done_cycle got=stall %b lo %0d want=stall 0 lo 42", stall, result_lo);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({busy, done, result_lo} !== {1'b1, 1'b0, 32'd42}) begin
      bad++;
      $display("FAIL b2b_second_launch got=busy %b done %b lo %0d want=busy 1 done 0 lo 42", busy, done, result_lo);
    end
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++;
    if ({lat, result_lo} !== {32'd33, 32'd15}) begin
      bad++;
      $display("FAIL b2b_second_op got=%0d %0d want=33 15", lat, result_lo);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    repeat (2) @(posedge clk);
    @(negedge clk);
    long_mul = 1'b1; signed_mul = 1'b0; accumulate = 1'b0;
    src_a = 32'd12; src_b = 32'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_inflight got=%b want=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, stall, n_flag, z_flag, result_hi, result_lo} !== 69'h0) begin
      bad++;
      $display("FAIL abort_outputs got=%b%b%b%b%b %h_%h want=all zero", busy, done, stall, n_flag, z_flag, result_hi, result_lo);
    end
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_long();
    test_accumulate();
    test_mid_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
